demod_frame_ctrl: RTL and testbench
===================================

Name: demod_frame_ctrl

Overview:
Frame-level controller that sequences the pulse-interval demodulator. It enables the demodulator and loads its 10-bit interval threshold, then consumes the demodulator's bit strobes. It hunts for a preamble, assembles a fixed-length payload, applies an inter-bit timeout and hands the frame to the MCU-side logic over a valid/ready handshake.

Parameters:
PREAMBLE_LEN, 8, preamble length in bits (1..16)
PREAMBLE, 8'hAB, preamble pattern; first received bit is the MSB
PAYLOAD_BITS, 16, payload bits per frame (1..32)
TIMEOUT_CYCLES, 60000, maximum clock cycles between bit strobes inside a payload (20-bit counter)

Ports:
clock  in  1  system clock, 10 MHz
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leave IDLE and begin hunting
stop  in  1  one-cycle pulse; return to IDLE from any state
cfg_threshold  in  10  interval threshold, sampled on start
bit_valid  in  1  one-cycle strobe from demodulator; a decoded bit is present
bit_value  in  1  decoded bit, qualified by bit_valid
demod_en  out  1  enable to the demodulator
demod_threshold  out  10  threshold driven to demodulator data_source
frame_data  out  PAYLOAD_BITS  assembled payload; first received bit is the MSB
frame_valid  out  1  frame available
frame_ready  in  1  consumer accepts the frame
frame_err  out  1  parity error qualifier, valid with frame_valid
timeout_pulse  out  1  one-cycle pulse when a partial payload is aborted
overrun  out  1  sticky; a bit was dropped while in HOLD
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All of demod_en, demod_threshold, frame_data, frame_valid, frame_err, timeout_pulse, overrun and busy are 0. Shift register, bit counter and timeout counter are 0.
- States: IDLE, HUNT, PAYLOAD, HOLD. All outputs are registered.
- IDLE:
  - demod_en=0; bit_valid is ignored.
  - On start: demod_threshold<=cfg_threshold, overrun<=0, preamble shift register cleared, state goes to HUNT on the next cycle.
  - If start and stop arrive together, stop wins: remain in IDLE and nothing is loaded.
- HUNT:
  - demod_en=1.
  - Each bit_valid shifts bit_value into a PREAMBLE_LEN-bit register.
  - The cycle after the register equals PREAMBLE, state=PAYLOAD; bit counter and timeout counter are cleared.
  - The match is checked on the updated register value, so the preamble bit that completes the match is never counted as payload.
  - No timeout applies in HUNT.
- PAYLOAD:
  - Each bit_valid shifts bit_value into frame_data, increments the bit counter and clears the timeout counter.
  - Otherwise the timeout counter increments each cycle.
  - When the counter reaches the frame length (PAYLOAD_BITS, or PAYLOAD_BITS+1 with parity): state=HOLD and frame_valid=1 on the following cycle. Latency from the last bit_valid to frame_valid is 1 cycle.
  - When the timeout counter reaches TIMEOUT_CYCLES: timeout_pulse=1 for one cycle, partial frame discarded, preamble register cleared, state=HUNT.
  - bit_valid in the same cycle as a timeout: the bit wins and the counter clears; no timeout.
- HOLD:
  - frame_valid=1; frame_data and frame_err are stable.
  - On frame_valid&&frame_ready: frame_valid<=0, state=HUNT with the preamble register cleared.
  - Any bit_valid in HOLD is dropped and sets overrun.
- stop:
  - From HUNT, PAYLOAD or HOLD: state goes to IDLE next cycle; demod_en=0; frame_valid=0; the held frame is discarded. frame_data keeps its value but is not qualified.
  - stop together with frame_ready in HOLD: the handshake completes, then the block goes to IDLE.
- start in a state other than IDLE is ignored. demod_threshold changes only on start from IDLE.
- Mid-operation reset: immediate return to the reset values above.

Optional Feature:
DEMOD_PARITY_EN
- Defined:
  - The frame is PAYLOAD_BITS+1 bits; the final bit is even parity over the payload.
  - The parity bit is not stored in frame_data.
  - frame_err=1 with frame_valid if the XOR of payload and parity bit is 1.
  - The frame is still delivered when frame_err=1.
- Undefined: the frame is PAYLOAD_BITS bits, frame_err is tied to 0, and there is no parity logic.

Test Plan:
- Reset then idle: reset low for 10 cycles, then high, with bit_valid strobes -> all outputs 0, state IDLE, demod_en=0.
- Nominal frame: cfg_threshold=460, start, send 0xAB followed by 0x1234 (16 bits) -> demod_threshold=460; frame_valid 1 cycle after the last bit; frame_data=16'h1234.
- Hold and overrun: hold frame_ready=0 for 100 cycles while sending 3 strobes -> frame_data stable and overrun=1. Assert frame_ready -> frame_valid drops and the next 0xAB+0x00FF frame yields 16'h00FF.
- Timeout: after the preamble, send 5 bits then 60000 idle cycles -> a single timeout_pulse. A strobe on cycle 60000 instead gives no pulse. A following full frame is received correctly.
- stop and start: stop mid-PAYLOAD -> IDLE and demod_en=0 next cycle. stop with frame_ready in HOLD -> handshake completes, then IDLE. start with stop -> stays IDLE.
- DEMOD_PARITY_EN: payload 0x0001 with parity 1 -> frame_err=0. Same payload with parity 0 -> frame_err=1 and frame_data=16'h0001.

Source files
------------

// File: rtl/demod_frame_ctrl.sv
// Frame controller for the pulse-interval demodulator: preamble hunt, payload assembly,
// inter-bit timeout and valid/ready hand-off. Optional even-parity check: DEMOD_PARITY_EN.
module demod_frame_ctrl #(
   parameter int unsigned                PREAMBLE_LEN   = 8,
   parameter logic [PREAMBLE_LEN-1:0]    PREAMBLE       = PREAMBLE_LEN'(8'hAB),
   parameter int unsigned                PAYLOAD_BITS   = 16,
   parameter int unsigned                TIMEOUT_CYCLES = 60000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic [9:0]              cfg_threshold,
   input  logic                    bit_valid,
   input  logic                    bit_value,
   output logic                    demod_en,
   output logic [9:0]              demod_threshold,
   output logic [PAYLOAD_BITS-1:0] frame_data,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    frame_err,
   output logic                    timeout_pulse,
   output logic                    overrun,
   output logic                    busy
);

   localparam int unsigned THR_W = 10;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned TMO_W = 20;
`ifdef DEMOD_PARITY_EN
   localparam int unsigned FRAME_LEN = PAYLOAD_BITS + 1;
`else
   localparam int unsigned FRAME_LEN = PAYLOAD_BITS;
`endif

   typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [PREAMBLE_LEN-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [THR_W-1:0]        thr_d;
   logic [PAYLOAD_BITS-1:0] data_d;
   logic                    demod_en_d, frame_valid_d, timeout_pulse_d, overrun_d, busy_d;
`ifdef DEMOD_PARITY_EN
   logic                    par_q, par_d;
   logic                    frame_err_d;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d         = state_q;
      sr_d            = sr_q;
      bit_cnt_d       = bit_cnt_q;
      tmo_cnt_d       = tmo_cnt_q;
      thr_d           = demod_threshold;
      data_d          = frame_data;
      frame_valid_d   = frame_valid;
      timeout_pulse_d = 1'b0;
      overrun_d       = overrun;
`ifdef DEMOD_PARITY_EN
      par_d           = par_q;
      frame_err_d     = frame_err;
`endif

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               thr_d     = cfg_threshold;
               overrun_d = 1'b0;
               sr_d      = '0;
               state_d   = HUNT;
            end
         end

         HUNT: begin
            if (stop) begin
               state_d = IDLE;
            end else if (bit_valid) begin
               sr_d = PREAMBLE_LEN'({sr_q, bit_value});
               // Match on the updated register so the closing preamble bit is not payload
               if (sr_d == PREAMBLE) begin
                  state_d   = PAYLOAD;
                  bit_cnt_d = '0;
                  tmo_cnt_d = '0;
`ifdef DEMOD_PARITY_EN
                  par_d     = 1'b0;
`endif
               end
            end
         end

         PAYLOAD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (bit_valid) begin
               tmo_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef DEMOD_PARITY_EN
               par_d = par_q ^ bit_value;
               if (bit_cnt_q != CNT_W'(PAYLOAD_BITS)) begin
                  data_d = PAYLOAD_BITS'({frame_data, bit_value});
               end
`else
               data_d = PAYLOAD_BITS'({frame_data, bit_value});
`endif
               if (bit_cnt_d == CNT_W'(FRAME_LEN)) begin
                  state_d       = HOLD;
                  frame_valid_d = 1'b1;
`ifdef DEMOD_PARITY_EN
                  frame_err_d   = par_d;
`endif
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               if (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES)) begin
                  timeout_pulse_d = 1'b1;
                  sr_d            = '0;
                  state_d         = HUNT;
               end
            end
         end

         HOLD: begin
            if (bit_valid) begin
               overrun_d = 1'b1;
            end
            // A simultaneous stop still lets the pending handshake complete
            if (frame_ready) begin
               frame_valid_d = 1'b0;
               sr_d          = '0;
               state_d       = stop ? IDLE : HUNT;
            end else if (stop) begin
               frame_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      demod_en_d = (state_d != IDLE);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         sr_q            <= '0;
         bit_cnt_q       <= '0;
         tmo_cnt_q       <= '0;
         demod_en        <= 1'b0;
         demod_threshold <= '0;
         frame_data      <= '0;
         frame_valid     <= 1'b0;
         timeout_pulse   <= 1'b0;
         overrun         <= 1'b0;
         busy            <= 1'b0;
`ifdef DEMOD_PARITY_EN
         par_q           <= 1'b0;
         frame_err       <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         sr_q            <= sr_d;
         bit_cnt_q       <= bit_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         demod_en        <= demod_en_d;
         demod_threshold <= thr_d;
         frame_data      <= data_d;
         frame_valid     <= frame_valid_d;
         timeout_pulse   <= timeout_pulse_d;
         overrun         <= overrun_d;
         busy            <= busy_d;
`ifdef DEMOD_PARITY_EN
         par_q           <= par_d;
         frame_err       <= frame_err_d;
`endif
      end
   end

`ifndef DEMOD_PARITY_EN
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// Directed bench for demod_frame_ctrl; the timeout is shortened so the run stays small.
module tb_demod_frame_ctrl;

   localparam int unsigned TMO = 1200;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [9:0]  cfg_threshold = '0;
   logic        bit_valid = 1'b0;
   logic        bit_value = 1'b0;
   logic        frame_ready = 1'b0;
   logic        demod_en;
   logic [9:0]  demod_threshold;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_err;
   logic        timeout_pulse;
   logic        overrun;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int n_tp  = 0;
   int tp_base;

   demod_frame_ctrl #(
      .PREAMBLE_LEN   (8),
      .PREAMBLE       (8'hAB),
      .PAYLOAD_BITS   (16),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .stop            (stop),
      .cfg_threshold   (cfg_threshold),
      .bit_valid       (bit_valid),
      .bit_value       (bit_value),
      .demod_en        (demod_en),
      .demod_threshold (demod_threshold),
      .frame_data      (frame_data),
      .frame_valid     (frame_valid),
      .frame_ready     (frame_ready),
      .frame_err       (frame_err),
      .timeout_pulse   (timeout_pulse),
      .overrun         (overrun),
      .busy            (busy)
   );

   always #50 clock = ~clock;

   always @(negedge clock) begin
      if (timeout_pulse === 1'b1) n_tp <= n_tp + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // MSB-first strobes with two idle cycles between bits; returns just after the last strobe edge
   task automatic send_word(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bit_value = v[i];
         bit_valid = 1'b1;
         tick();
         bit_valid = 1'b0;
         bit_value = 1'b0;
         if (i != 0) repeat (2) tick();
      end
   endtask

   task automatic send_payload(input logic [15:0] d, input int skip);
      send_word(32'(d), 16 - skip);
`ifdef DEMOD_PARITY_EN
      repeat (2) tick();
      send_word(32'(^d), 1);
`endif
   endtask

   task automatic send_frame(input logic [15:0] d);
      send_word(32'hAB, 8);
      repeat (3) tick();
      send_payload(d, 0);
   endtask

   task automatic ack();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      chk("ack_fv_low", 32'(frame_valid), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},   32'(demod_en), 32'd0);
      chk({tag, "_thr"},  32'(demod_threshold), 32'd0);
      chk({tag, "_fd"},   32'(frame_data), 32'd0);
      chk({tag, "_fv"},   32'(frame_valid), 32'd0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
      chk({tag, "_tp"},   32'(timeout_pulse), 32'd0);
      chk({tag, "_ovr"},  32'(overrun), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset held for 10 cycles with strobes toggling underneath
      for (int i = 0; i < 10; i++) begin
         bit_valid = i[0];
         bit_value = 1'b1;
         tick();
      end
      chk_all_zero("rst");
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bit_valid = ~i[0];
         tick();
      end
      bit_valid = 1'b0;
      chk_all_zero("idle");

      // Nominal frame
      cfg_threshold = 10'd460;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_thr", 32'(demod_threshold), 32'd460);
      chk("start_en", 32'(demod_en), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      send_word(32'hAB, 8);
      tick();
      chk("pre_fv_low", 32'(frame_valid), 32'd0);
      send_payload(16'h1234, 0);
      chk("nom_fv_lat1", 32'(frame_valid), 32'd1);
      chk("nom_fd", 32'(frame_data), 32'h1234);
      chk("nom_ferr", 32'(frame_err), 32'd0);
      chk("nom_ovr", 32'(overrun), 32'd0);

      // Hold for 100 cycles with three dropped strobes
      for (int i = 0; i < 100; i++) begin
         bit_valid = (i % 40 == 10);
         bit_value = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      chk("hold_fd", 32'(frame_data), 32'h1234);
      chk("hold_fv", 32'(frame_valid), 32'd1);
      chk("hold_ovr", 32'(overrun), 32'd1);
      ack();
      chk("ack_busy", 32'(busy), 32'd1);
      chk("ack_ovr_sticky", 32'(overrun), 32'd1);
      send_frame(16'h00FF);
      chk("f2_fv", 32'(frame_valid), 32'd1);
      chk("f2_fd", 32'(frame_data), 32'h00FF);
      ack();

      // Timeout after a partial payload
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h16, 5);
      tp_base = n_tp;
      repeat (TMO - 1) tick();
      chk("tmo_early", 32'(timeout_pulse), 32'd0);
      tick();
      chk("tmo_pulse", 32'(timeout_pulse), 32'd1);
      tick();
      chk("tmo_pulse_end", 32'(timeout_pulse), 32'd0);
      repeat (20) tick();
      chk("tmo_count", 32'(n_tp - tp_base), 32'd1);
      chk("tmo_fv", 32'(frame_valid), 32'd0);
      chk("tmo_busy", 32'(busy), 32'd1);
      send_frame(16'hBEEF);
      chk("tmo_next_fv", 32'(frame_valid), 32'd1);
      chk("tmo_next_fd", 32'(frame_data), 32'hBEEF);
      ack();

      // Strobe landing exactly on the timeout cycle keeps the frame alive
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h18, 5);
      tp_base = n_tp;
      repeat (TMO - 1) tick();
      send_payload(16'hC3A5, 5);
      chk("edge_no_tp", 32'(n_tp - tp_base), 32'd0);
      chk("edge_fv", 32'(frame_valid), 32'd1);
      chk("edge_fd", 32'(frame_data), 32'hC3A5);
      ack();

      // stop mid-payload
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h5, 4);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_en", 32'(demod_en), 32'd0);
      chk("stop_fv", 32'(frame_valid), 32'd0);
      chk("stop_thr", 32'(demod_threshold), 32'd460);

      // start together with stop is ignored
      cfg_threshold = 10'd123;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      tick();
      chk("ss_busy", 32'(busy), 32'd0);
      chk("ss_thr", 32'(demod_threshold), 32'd460);
      chk("ss_ovr", 32'(overrun), 32'd1);

      // start loads threshold and clears overrun; a second start is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("s2_thr", 32'(demod_threshold), 32'd123);
      chk("s2_ovr", 32'(overrun), 32'd0);
      cfg_threshold = 10'd77;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("s3_thr_kept", 32'(demod_threshold), 32'd123);
      send_frame(16'h5A5A);
      chk("sr_fv", 32'(frame_valid), 32'd1);
      stop = 1'b1;
      frame_ready = 1'b1;
      tick();
      stop = 1'b0;
      frame_ready = 1'b0;
      chk("sr_fv_low", 32'(frame_valid), 32'd0);
      chk("sr_busy", 32'(busy), 32'd0);
      chk("sr_en", 32'(demod_en), 32'd0);
      chk("sr_fd_kept", 32'(frame_data), 32'h5A5A);

      // Parity qualifier
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef DEMOD_PARITY_EN
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h0001, 16);
      repeat (2) tick();
      send_word(32'h1, 1);
      chk("par_ok_fv", 32'(frame_valid), 32'd1);
      chk("par_ok_err", 32'(frame_err), 32'd0);
      ack();
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h0001, 16);
      repeat (2) tick();
      send_word(32'h0, 1);
      chk("par_bad_fv", 32'(frame_valid), 32'd1);
      chk("par_bad_err", 32'(frame_err), 32'd1);
      chk("par_bad_fd", 32'(frame_data), 32'h0001);
      ack();
`else
      send_frame(16'h0001);
      chk("nopar_fv", 32'(frame_valid), 32'd1);
      chk("nopar_err", 32'(frame_err), 32'd0);
      chk("nopar_fd", 32'(frame_data), 32'h0001);
      ack();
`endif

      // Asynchronous reset in the middle of a payload
      send_word(32'hAB, 8);
      repeat (2) tick();
      send_word(32'h7, 3);
      #10;
      reset = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      #20;
      reset = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
